// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin front end for a shared combinational ALU.
// A grant registers the winner's operands onto the ALU drive for one EXEC
// cycle; the result is captured into a response that waits for rsp_ready.
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4,
    parameter int MAXOP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [OPW-1:0]   op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [OPW-1:0]   op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt1,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    input  logic             rsp_ready,
    output logic             busy
);

    localparam logic [OPW-1:0] MAX_OPCODE = OPW'(MAXOP);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    state_t next_state;
    logic   prio;
    logic   owner;
    logic   grant;
    logic   winner;

    // Choose the winner and decide whether a grant is issued at the next edge
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        winner     = 1'b0;
        if (req0 && req1) begin
            winner = prio;
        end else begin
            winner = req1;
        end
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    next_state = EXEC;
                    grant      = 1'b1;
                end
            end
            EXEC: begin
                next_state = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (req0 || req1) begin
                        next_state = EXEC;
                        grant      = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture the winner's operands and hand priority to the loser on each grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio   <= 1'b0;
            owner  <= 1'b0;
            alu_op <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
        end else if (grant) begin
            prio   <= ~winner;
            owner  <= winner;
            alu_op <= winner ? op1 : op0;
            alu_a  <= winner ? a1 : a0;
            alu_b  <= winner ? b1 : b0;
        end
    end

    // Latch the ALU result at the end of EXEC; illegal opcodes report zero data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (state == EXEC) begin
            rsp_id <= owner;
            if (alu_op > MAX_OPCODE) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end else begin
                rsp_data <= alu_result;
                rsp_err  <= 1'b0;
            end
        end
    end

    assign gnt0      = (state == EXEC) && !owner;
    assign gnt1      = (state == EXEC) && owner;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter with a
// scoreboard; the bench also plays the role of the shared combinational ALU.
module tb_alu_arbiter;

    localparam int WIDTH = 16;
    localparam int OPW   = 4;
    localparam int MAXOP = 8;

    typedef struct {
        logic             id;
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_data;
        logic             exp_err;
        int               age;
    } txn_t;

    logic             clk;
    logic             rst_n;
    logic             req0;
    logic [OPW-1:0]   op0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             gnt0;
    logic             req1;
    logic [OPW-1:0]   op1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt1;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic             rsp_ready;
    logic             busy;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    txn_t pend0[$];
    txn_t pend1[$];
    txn_t inflight[$];
    logic model_prio;

    alu_arbiter #(
        .WIDTH(WIDTH),
        .OPW  (OPW),
        .MAXOP(MAXOP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .op0       (op0),
        .a0        (a0),
        .b0        (b0),
        .gnt0      (gnt0),
        .req1      (req1),
        .op1       (op1),
        .a1        (a1),
        .b1        (b1),
        .gnt1      (gnt1),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_result(alu_result),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    // Behavioural ALU: add, sub, even parity of upper/lower half, compares
    function automatic logic [WIDTH-1:0] alu_model(input logic [OPW-1:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r[0] = ~^a[WIDTH-1:WIDTH/2];
            4'd3:    r[0] = ~^a[WIDTH/2-1:0];
            4'd4:    r[0] = (a >= b);
            4'd5:    r[0] = a[WIDTH-1];
            4'd6:    r[0] = (a == '0);
            4'd7:    r[0] = (a == b);
            4'd8:    r[0] = (a != b);
            default: r = 16'hDEAD;
        endcase
        return r;
    endfunction

    assign alu_result = alu_model(alu_op, alu_a, alu_b);

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always terminates
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Raise a request and record the response it must eventually produce
    task automatic applyStimulus(input int port, input logic [OPW-1:0] op,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        txn_t t;
        t.id  = (port == 1);
        t.op  = op;
        t.a   = a;
        t.b   = b;
        t.age = 0;
        if (int'(op) > MAXOP) begin
            t.exp_data = '0;
            t.exp_err  = 1'b1;
        end else begin
            t.exp_data = alu_model(op, a, b);
            t.exp_err  = 1'b0;
        end
        if (port == 0) begin
            op0 = op; a0 = a; b0 = b; req0 = 1'b1;
            pend0.push_back(t);
        end else begin
            op1 = op; a1 = a; b1 = b; req1 = 1'b1;
            pend1.push_back(t);
        end
    endtask

    // Lower a request; an ungranted one is forgotten by the scoreboard
    task automatic dropReq(input int port);
        if (port == 0) begin
            req0 = 1'b0;
            if (!gnt0 && pend0.size() > 0) void'(pend0.pop_back());
        end else begin
            req1 = 1'b0;
            if (!gnt1 && pend1.size() > 0) void'(pend1.pop_back());
        end
    endtask

    task automatic issueRandom(input int port);
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        op = OPW'($urandom_range(0, 10));
        a  = WIDTH'($urandom);
        b  = ($urandom_range(0, 3) == 0) ? a : WIDTH'($urandom);
        applyStimulus(port, op, a, b);
    endtask

    task automatic randomPort(input int port, input logic granted, input logic active);
        if (granted) begin
            if ($urandom_range(0, 3) == 0) dropReq(port);
            else issueRandom(port);
        end else if (active) begin
            if ($urandom_range(0, 15) == 0) dropReq(port);
        end else if ($urandom_range(0, 2) == 0) begin
            issueRandom(port);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_gnt0"}, gnt0, 0);
        checkOutput({tag, "_gnt1"}, gnt1, 0);
        checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
        checkOutput({tag, "_rsp_id"}, rsp_id, 0);
        checkOutput({tag, "_rsp_data"}, rsp_data, 0);
        checkOutput({tag, "_rsp_err"}, rsp_err, 0);
        checkOutput({tag, "_alu_op"}, alu_op, 0);
        checkOutput({tag, "_alu_a"}, alu_a, 0);
        checkOutput({tag, "_alu_b"}, alu_b, 0);
    endtask

    // Monitor: sampled just after each falling edge, compares what the DUT
    // shows against the scoreboard and the round-robin/occupancy rules
    initial begin : monitor
        logic             pr0, pr1, prs;
        logic [OPW-1:0]   palu_op;
        logic [WIDTH-1:0] palu_a, palu_b;
        logic             granted, w, exp_grant, exp_valid;
        txn_t             t;
        pr0 = 1'b0; pr1 = 1'b0; prs = 1'b0;
        palu_op = '0; palu_a = '0; palu_b = '0;
        model_prio = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!prs) begin
                inflight.delete();
                model_prio = 1'b0;
                checkOutput("mon_rst_busy", busy, 0);
                checkOutput("mon_rst_gnt", {gnt1, gnt0}, 0);
                checkOutput("mon_rst_valid", rsp_valid, 0);
                checkOutput("mon_rst_data", rsp_data, 0);
                checkOutput("mon_rst_alu_op", alu_op, 0);
                checkOutput("mon_rst_alu_a", alu_a, 0);
            end else begin
                granted   = gnt0 | gnt1;
                exp_grant = (pr0 | pr1) && (inflight.size() == 0);
                checkOutput("mon_gnt_onehot", gnt0 & gnt1, 0);
                checkOutput("mon_grant_expected", granted, exp_grant);
                if (inflight.size() > 0) begin
                    t = inflight[0];
                    t.age = t.age + 1;
                    inflight[0] = t;
                end
                if (granted) begin
                    w = gnt1;
                    checkOutput("mon_winner_requested", w ? pr1 : pr0, 1);
                    if (pr0 && pr1) checkOutput("mon_rr_winner", w, model_prio);
                    model_prio = ~w;
                    if ((w ? pend1.size() : pend0.size()) == 0) begin
                        checkOutput("mon_grant_has_txn", 0, 1);
                    end else begin
                        if (w) t = pend1.pop_front();
                        else   t = pend0.pop_front();
                        checkOutput("mon_alu_op", alu_op, t.op);
                        checkOutput("mon_alu_a", alu_a, t.a);
                        checkOutput("mon_alu_b", alu_b, t.b);
                        t.age = 0;
                        inflight.push_back(t);
                    end
                end else begin
                    checkOutput("mon_alu_op_hold", alu_op, palu_op);
                    checkOutput("mon_alu_a_hold", alu_a, palu_a);
                    checkOutput("mon_alu_b_hold", alu_b, palu_b);
                end
                exp_valid = (inflight.size() > 0) && (inflight[0].age >= 1);
                checkOutput("mon_rsp_valid", rsp_valid, exp_valid);
                if (rsp_valid && exp_valid) begin
                    checkOutput("mon_rsp_id", rsp_id, inflight[0].id);
                    checkOutput("mon_rsp_data", rsp_data, inflight[0].exp_data);
                    checkOutput("mon_rsp_err", rsp_err, inflight[0].exp_err);
                    if (rsp_ready) void'(inflight.pop_front());
                end
            end
            pr0 = req0; pr1 = req1; prs = rst_n;
            palu_op = alu_op; palu_a = alu_a; palu_b = alu_b;
        end
    end

    // Stimulus: directed scenarios first, then a randomized soak
    initial begin : stimulus
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0 = 1'b0; op0 = '0; a0 = '0; b0 = '0;
        req1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        checkResetState("reset");

        // Single add from requester 0, issued on the first edge out of reset
        rst_n = 1'b1;
        applyStimulus(0, 4'd0, 16'd5, 16'd7);
        @(negedge clk);
        checkOutput("add_gnt0", gnt0, 1);
        checkOutput("add_gnt1", gnt1, 0);
        checkOutput("add_busy", busy, 1);
        dropReq(0);
        @(negedge clk);
        checkOutput("add_valid", rsp_valid, 1);
        checkOutput("add_data", rsp_data, 12);
        checkOutput("add_id", rsp_id, 0);
        checkOutput("add_err", rsp_err, 0);
        @(negedge clk);
        checkOutput("add_idle_valid", rsp_valid, 0);
        checkOutput("add_idle_busy", busy, 0);

        // Even parity of the lower and upper byte from requester 1
        applyStimulus(1, 4'd3, 16'h0003, 16'h0000);
        @(negedge clk);
        checkOutput("evl_gnt1", gnt1, 1);
        dropReq(1);
        @(negedge clk);
        checkOutput("evl_data", rsp_data, 1);
        checkOutput("evl_id", rsp_id, 1);
        @(negedge clk);
        applyStimulus(1, 4'd2, 16'h0100, 16'h0000);
        @(negedge clk);
        checkOutput("evu_gnt1", gnt1, 1);
        dropReq(1);
        @(negedge clk);
        checkOutput("evu_valid", rsp_valid, 1);
        checkOutput("evu_data", rsp_data, 0);
        checkOutput("evu_err", rsp_err, 0);
        @(negedge clk);

        // Opcode above the legal range
        applyStimulus(0, 4'd9, 16'h1234, 16'h0001);
        @(negedge clk);
        dropReq(0);
        @(negedge clk);
        checkOutput("illegal_valid", rsp_valid, 1);
        checkOutput("illegal_err", rsp_err, 1);
        checkOutput("illegal_data", rsp_data, 0);
        @(negedge clk);

        // Back-pressure with requester 1 waiting behind a held response
        applyStimulus(0, 4'd0, 16'd1, 16'd2);
        rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_gnt0", gnt0, 1);
        dropReq(0);
        applyStimulus(1, 4'd1, 16'd10, 16'd3);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_valid", rsp_valid, 1);
            checkOutput("bp_hold_data", rsp_data, 3);
            checkOutput("bp_hold_id", rsp_id, 0);
            checkOutput("bp_no_gnt1", gnt1, 0);
            if (i < 4) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_gnt1", gnt1, 1);
        checkOutput("bp_busy", busy, 1);
        checkOutput("bp_valid_low", rsp_valid, 0);
        dropReq(1);
        @(negedge clk);
        checkOutput("bp_data", rsp_data, 7);
        checkOutput("bp_id", rsp_id, 1);
        @(negedge clk);

        // Both requesters held from reset: grants alternate 0,1,0,1
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 4'd0, 16'd1, 16'd1);
        applyStimulus(1, 4'd7, 16'd9, 16'd4);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c % 2 == 0) begin
                checkOutput("rr_gnt0", gnt0, ((c / 2) % 2) == 0);
                checkOutput("rr_gnt1", gnt1, ((c / 2) % 2) == 1);
                if (gnt0) applyStimulus(0, 4'd0, 16'd1, 16'd1);
                if (gnt1) applyStimulus(1, 4'd7, 16'd9, 16'd4);
            end else begin
                checkOutput("rr_valid", rsp_valid, 1);
                checkOutput("rr_id", rsp_id, ((c - 1) / 2) % 2);
            end
        end
        dropReq(0);
        dropReq(1);
        repeat (2) @(negedge clk);

        // Reset asserted during EXEC aborts the operation
        applyStimulus(0, 4'd0, 16'd3, 16'd4);
        @(negedge clk);
        checkOutput("abort_gnt0", gnt0, 1);
        rst_n = 1'b0;
        dropReq(0);
        @(negedge clk);
        checkResetState("abort");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_after_valid", rsp_valid, 0);
        checkOutput("abort_after_gnt0", gnt0, 0);
        @(negedge clk);
        checkOutput("abort_after2_valid", rsp_valid, 0);

        // Randomized traffic with random back-pressure and withdrawals
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            rsp_ready = ($urandom_range(0, 3) != 0);
            randomPort(0, gnt0, req0);
            randomPort(1, gnt1, req1);
        end

        // Drain everything still in flight
        @(negedge clk);
        rsp_ready = 1'b1;
        dropReq(0);
        dropReq(1);
        repeat (6) @(negedge clk);
        checkOutput("drain_inflight", inflight.size(), 0);
        checkOutput("drain_pend0", pend0.size(), 0);
        checkOutput("drain_pend1", pend1.size(), 0);
        checkOutput("drain_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
